sdspi_host_arbiter: RTL and testbench
=====================================

# sdspi_host_arbiter

Two-requester arbiter that shares one sdspihost between the autotest sequencer (port m0) and the SD SPI unit under test (port m1). It replaces the static `sdspi_ctrl_mux` selection with transaction-level ownership: it grants the host to one requester and holds the grant until that requester's transaction drains. It masks the host handshake from the non-owner and aborts hung owners with a watchdog. It sits between both requesters and the single sdspihost instance; `host_data_out` fans out to both requesters outside this block.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default `32'd50_000_000`: owner-stall limit in clk cycles.

Command vector bit map, used by all `*_cmd` ports: [5] rst, [4] r_multi_block, [3] r_block, [2] r_byte, [1] w_block, [0] w_byte.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m0_cmd` / `m1_cmd`  in  6  requester command strobes (bit map above).
- `m0_block_addr` / `m1_block_addr`  in  32  requester block address.
- `m0_data_in` / `m1_data_in`  in  8  requester write byte.
- `m0_busy` / `m1_busy`  out  1  host busy as seen by the requester.
- `m0_err`, `m0_crc_err` / `m1_err`, `m1_crc_err`  out  1  routed host error flags.
- `host_cmd`  out  6  strobes to sdspihost.
- `host_block_addr`  out  32  to sdspihost.
- `host_data_in`  out  8  to sdspihost.
- `host_busy`, `host_err`, `host_crc_err`  in  1  from sdspihost.
- `grant`  out  2  one-hot owner; `2'b00` when none.
- `timeout_err`  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- Request: `req_i = |mi_cmd`.
- Registered FSM with states IDLE, OWN0, OWN1, DRAIN.
- **IDLE**
  - If only req0 is high, go to OWN0; if only req1 is high, go to OWN1.
  - If both are high, grant the requester that is not `last_owner`.
  - `last_owner` resets to 1, so m0 wins the first tie.
  - `last_owner` updates on every entry to an OWN state.
- **OWNi** (grant = one-hot i)
  - `host_cmd`, `host_block_addr`, `host_data_in` = mi inputs (combinational mux).
  - `mi_busy = host_busy`; `mi_err`/`mi_crc_err` = host flags.
- **Non-owner, and every output in IDLE/DRAIN**
  - busy = 0, err = 0, crc_err = 0. This stalls a requester at its "strobe, wait busy=1" step without a false completion.
  - `host_cmd = 0`, `host_block_addr = 0`, `host_data_in = 8'hFF`.
- **Release:** in OWNi, when `mi_cmd == 0 && host_busy == 0`, go to DRAIN.
  - While `host_busy = 1`, ownership holds even with `mi_cmd = 0`. This covers reset/end-of-test wait phases.
- **DRAIN:** one cycle with `host_cmd = 0`, then IDLE unconditionally.
- **Watchdog**
  - The counter clears on entry to an OWN state.
  - In OWNi it increments each cycle with `mi_cmd != 0 && host_busy == 0`. It holds otherwise.
  - At `count == TIMEOUT_CYCLES - 1` on an incrementing cycle: `timeout_err <= 1`, next state DRAIN.
- Width rules:
  - Counter is 32-bit and saturates; it never wraps while in an OWN state.
  - `grant` is never `2'b11`.

## Timing
- Request sampled in IDLE at cycle n → grant and `host_cmd` visible in cycle n+1 (1-cycle latency).
- Release condition at cycle n → DRAIN in n+1 → IDLE in n+2 → earliest next grant in n+3.
- Release and the other requester's request in the same cycle: the other requester is granted in n+3. There is no bypass of DRAIN.
- Owner's request continuously high: no preemption.
- Between transactions the owner may lose the host to a waiting requester (round-robin). Requesters re-strobe naturally.
- Reset asserted, including mid-transaction: all outputs go to reset values immediately and asynchronously.
  - Reset values: state IDLE, grant 0, `host_cmd` 0, addr 0, `host_data_in` FF, all busy/err 0, `timeout_err` 0, counter 0, `last_owner` 1.
  - The in-flight host transaction is abandoned; requesters re-issue.
- Deassertion of reset takes effect on the next rising clk edge.

## Structure
- Shared package `sdspi_arb_pkg`:
  - state encoding constants `ARB_IDLE`/`ARB_OWN0`/`ARB_OWN1`/`ARB_DRAIN` (2-bit);
  - command bit indices `CMD_RST`..`CMD_W_BYTE`;
  - idle byte `8'hFF`.
- Sub-module `sdspi_arb_watchdog`: 32-bit saturating counter with clear, enable and terminal-count output; async active-low reset.

## Test plan
- m0 `cmd = 6'b001000` with host_busy pulsing 1 for 5 cycles then 0, then m0 cmd → 0 → `grant = 01` one cycle after request; `host_cmd` mirrors m0; DRAIN; `grant = 00`.
- m0 and m1 request in the same IDLE cycle, twice in succession → first grant 01, second grant 10.
- m0 owns with host_busy = 1 and cmd = 0; m1 requests → `m1_busy = 0`, `grant` stays 01 until host_busy falls; m1 granted 3 cycles after release.
- `TIMEOUT_CYCLES = 16`; m1 holds `cmd = 6'b000100`, host_busy = 0 → `timeout_err = 1` after exactly 16 owner cycles, then DRAIN, IDLE, and a regrant allowed.
- Reset pulled low during OWN1 with host_busy = 1 → same cycle: `grant = 00`, `host_cmd = 0`, `host_data_in = FF`, `m1_busy = 0`, `timeout_err = 0`.
- `host_err = 1` during OWN0 → `m0_err = 1`, `m1_err = 0`.

Source files
------------

// File: rtl/sdspi_arb_pkg.sv
// Shared definitions for the sdspihost two-requester arbiter.
package sdspi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN0  = 2'd1,
    ARB_OWN1  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_e;

  localparam int unsigned CMD_RST     = 5;
  localparam int unsigned CMD_R_MULTI = 4;
  localparam int unsigned CMD_R_BLOCK = 3;
  localparam int unsigned CMD_R_BYTE  = 2;
  localparam int unsigned CMD_W_BLOCK = 1;
  localparam int unsigned CMD_W_BYTE  = 0;
  localparam int unsigned CMD_W       = CMD_RST + 1;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  function automatic logic cmd_req(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_RST] | cmd[CMD_R_MULTI] | cmd[CMD_R_BLOCK] |
           cmd[CMD_R_BYTE] | cmd[CMD_W_BLOCK] | cmd[CMD_W_BYTE];
  endfunction

endpackage

// File: rtl/sdspi_arb_watchdog.sv
// Saturating 32-bit stall counter; tc_o flags the final enabled cycle before LIMIT.
module sdspi_arb_watchdog #(
  parameter logic [31:0] LIMIT = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign tc_o = en_i && (count_q == (LIMIT - 32'd1));

endmodule

// File: rtl/sdspi_host_arbiter.sv
// Transaction-level arbiter sharing one sdspihost between the autotest
// sequencer (m0) and the SD SPI unit under test (m1).
module sdspi_host_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] m0_cmd,
  input  logic [31:0]      m0_block_addr,
  input  logic [7:0]       m0_data_in,
  output logic             m0_busy,
  output logic             m0_err,
  output logic             m0_crc_err,
  input  logic [CMD_W-1:0] m1_cmd,
  input  logic [31:0]      m1_block_addr,
  input  logic [7:0]       m1_data_in,
  output logic             m1_busy,
  output logic             m1_err,
  output logic             m1_crc_err,
  output logic [CMD_W-1:0] host_cmd,
  output logic [31:0]      host_block_addr,
  output logic [7:0]       host_data_in,
  input  logic             host_busy,
  input  logic             host_err,
  input  logic             host_crc_err,
  output logic [1:0]       grant,
  output logic             timeout_err
);

  arb_state_e state_q;
  logic [1:0] grant_q;
  logic       last_owner_q;
  logic       timeout_q;

  logic req0, req1, take0, take1;
  logic wd_clr, wd_en, wd_tc;

  // last_owner_q = 1 means m1 was granted last, so m0 wins the next tie.
  always_comb begin
    req0   = cmd_req(m0_cmd);
    req1   = cmd_req(m1_cmd);
    take0  = (state_q == ARB_IDLE) && req0 && (!req1 || last_owner_q);
    take1  = (state_q == ARB_IDLE) && req1 && (!req0 || !last_owner_q);
    wd_clr = take0 || take1;
    wd_en  = !host_busy && (((state_q == ARB_OWN0) && req0) ||
                            ((state_q == ARB_OWN1) && req1));
  end

  sdspi_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_owner_q <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (take0) begin
            state_q      <= ARB_OWN0;
            grant_q      <= 2'b01;
            last_owner_q <= 1'b0;
          end else if (take1) begin
            state_q      <= ARB_OWN1;
            grant_q      <= 2'b10;
            last_owner_q <= 1'b1;
          end
        end
        ARB_OWN0, ARB_OWN1: begin
          if (wd_tc) begin
            timeout_q <= 1'b1;
            state_q   <= ARB_DRAIN;
            grant_q   <= '0;
          end else if (!host_busy &&
                       (((state_q == ARB_OWN0) && !req0) ||
                        ((state_q == ARB_OWN1) && !req1))) begin
            state_q <= ARB_DRAIN;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    host_cmd        = '0;
    host_block_addr = '0;
    host_data_in    = IDLE_BYTE;
    m0_busy         = 1'b0;
    m0_err          = 1'b0;
    m0_crc_err      = 1'b0;
    m1_busy         = 1'b0;
    m1_err          = 1'b0;
    m1_crc_err      = 1'b0;
    case (state_q)
      ARB_OWN0: begin
        host_cmd        = m0_cmd;
        host_block_addr = m0_block_addr;
        host_data_in    = m0_data_in;
        m0_busy         = host_busy;
        m0_err          = host_err;
        m0_crc_err      = host_crc_err;
      end
      ARB_OWN1: begin
        host_cmd        = m1_cmd;
        host_block_addr = m1_block_addr;
        host_data_in    = m1_data_in;
        m1_busy         = host_busy;
        m1_err          = host_err;
        m1_crc_err      = host_crc_err;
      end
      default: ;
    endcase
  end

  assign grant       = grant_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sdspi_host_arbiter.sv
// Directed-vector bench for sdspi_host_arbiter with a short watchdog limit.
module tb_sdspi_host_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  m0_cmd = '0, m1_cmd = '0;
  logic [31:0] m0_block_addr = '0, m1_block_addr = '0;
  logic [7:0]  m0_data_in = '0, m1_data_in = '0;
  logic        m0_busy, m0_err, m0_crc_err;
  logic        m1_busy, m1_err, m1_crc_err;
  logic [5:0]  host_cmd;
  logic [31:0] host_block_addr;
  logic [7:0]  host_data_in;
  logic        host_busy = 1'b0, host_err = 1'b0, host_crc_err = 1'b0;
  logic [1:0]  grant;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdspi_host_arbiter #(
    .TIMEOUT_CYCLES (32'd16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .m0_cmd          (m0_cmd),
    .m0_block_addr   (m0_block_addr),
    .m0_data_in      (m0_data_in),
    .m0_busy         (m0_busy),
    .m0_err          (m0_err),
    .m0_crc_err      (m0_crc_err),
    .m1_cmd          (m1_cmd),
    .m1_block_addr   (m1_block_addr),
    .m1_data_in      (m1_data_in),
    .m1_busy         (m1_busy),
    .m1_err          (m1_err),
    .m1_crc_err      (m1_crc_err),
    .host_cmd        (host_cmd),
    .host_block_addr (host_block_addr),
    .host_data_in    (host_data_in),
    .host_busy       (host_busy),
    .host_err        (host_err),
    .host_crc_err    (host_crc_err),
    .grant           (grant),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_hcmd", 32'(host_cmd), 32'h0);
    chk("rst_haddr", host_block_addr, 32'h0);
    chk("rst_hdata", 32'(host_data_in), 32'hFF);
    chk("rst_tmo", 32'(timeout_err), 32'h0);
    step(); step();
    rst = 1'b1;
    step();
    chk("idle_grant", 32'(grant), 32'h0);

    // Simultaneous requests twice: m0 wins first tie, m1 the second
    m0_cmd = 6'b000100; m1_cmd = 6'b000010;
    m0_block_addr = 32'hAAAA_0000; m1_block_addr = 32'hBBBB_0001;
    step();
    chk("tie1_grant", 32'(grant), 32'h1);
    chk("tie1_hcmd", 32'(host_cmd), 32'h04);
    chk("tie1_haddr", host_block_addr, 32'hAAAA_0000);
    m0_cmd = 6'b000000;
    step();
    chk("tie1_drain", 32'(grant), 32'h0);
    step();
    chk("tie1_idle", 32'(grant), 32'h0);
    m0_cmd = 6'b000100;
    step();
    chk("tie2_grant", 32'(grant), 32'h2);
    chk("tie2_hcmd", 32'(host_cmd), 32'h02);
    chk("tie2_haddr", host_block_addr, 32'hBBBB_0001);
    m1_cmd = 6'b000000;
    step(); step(); step();
    chk("tie3_grant", 32'(grant), 32'h1);
    m0_cmd = 6'b000000;
    step(); step();
    chk("tie3_idle", 32'(grant), 32'h0);

    // Single m0 transaction with a 5-cycle busy pulse
    m0_cmd = 6'b001000; m0_block_addr = 32'h1234_5678; m0_data_in = 8'hA5;
    #1;
    chk("t1_pre_grant", 32'(grant), 32'h0);
    chk("t1_pre_hcmd", 32'(host_cmd), 32'h0);
    step();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_hcmd", 32'(host_cmd), 32'h08);
    chk("t1_haddr", host_block_addr, 32'h1234_5678);
    chk("t1_hdata", 32'(host_data_in), 32'hA5);
    host_busy = 1'b1;
    #1;
    chk("t1_m0busy", 32'(m0_busy), 32'h1);
    chk("t1_m1busy", 32'(m1_busy), 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("t1_hold", 32'(grant), 32'h1);
    host_busy = 1'b0; m0_cmd = 6'b000000;
    step();
    chk("t1_drain_grant", 32'(grant), 32'h0);
    chk("t1_drain_hcmd", 32'(host_cmd), 32'h0);
    chk("t1_drain_hdata", 32'(host_data_in), 32'hFF);
    step();
    chk("t1_idle_grant", 32'(grant), 32'h0);

    // m0 holds during busy with cmd=0; m1 waits, granted 3 cycles after release
    m0_cmd = 6'b100000;
    step();
    chk("t3_grant", 32'(grant), 32'h1);
    host_busy = 1'b1; m0_cmd = 6'b000000; m1_cmd = 6'b000001;
    #1;
    chk("t3_m1busy", 32'(m1_busy), 32'h0);
    step(); step(); step();
    chk("t3_hold_grant", 32'(grant), 32'h1);
    chk("t3_hold_m1busy", 32'(m1_busy), 32'h0);
    chk("t3_hold_hcmd", 32'(host_cmd), 32'h0);
    host_busy = 1'b0;
    step();
    chk("t3_n1", 32'(grant), 32'h0);
    step();
    chk("t3_n2", 32'(grant), 32'h0);
    step();
    chk("t3_n3_grant", 32'(grant), 32'h2);
    chk("t3_n3_hcmd", 32'(host_cmd), 32'h01);
    m1_cmd = 6'b000000;
    step(); step();

    // Error routing to the owner only
    m0_cmd = 6'b000001;
    step();
    chk("err_grant", 32'(grant), 32'h1);
    host_err = 1'b1; host_crc_err = 1'b1;
    #1;
    chk("err_m0err", 32'(m0_err), 32'h1);
    chk("err_m0crc", 32'(m0_crc_err), 32'h1);
    chk("err_m1err", 32'(m1_err), 32'h0);
    chk("err_m1crc", 32'(m1_crc_err), 32'h0);
    host_err = 1'b0; host_crc_err = 1'b0; m0_cmd = 6'b000000;
    step(); step();

    // Watchdog: 16 stalled owner cycles then DRAIN, IDLE, regrant
    m1_cmd = 6'b000100;
    step();
    chk("wd_grant", 32'(grant), 32'h2);
    chk("wd_tmo_c1", 32'(timeout_err), 32'h0);
    for (int i = 0; i < 15; i++) step();
    chk("wd_c16_grant", 32'(grant), 32'h2);
    chk("wd_c16_tmo", 32'(timeout_err), 32'h0);
    step();
    chk("wd_drain_tmo", 32'(timeout_err), 32'h1);
    chk("wd_drain_grant", 32'(grant), 32'h0);
    step();
    chk("wd_idle_grant", 32'(grant), 32'h0);
    step();
    chk("wd_regrant", 32'(grant), 32'h2);
    chk("wd_sticky", 32'(timeout_err), 32'h1);

    // Asynchronous reset mid-transaction in OWN1
    m1_data_in = 8'h3C;
    host_busy = 1'b1;
    #1;
    chk("ar_m1busy_pre", 32'(m1_busy), 32'h1);
    chk("ar_hdata_pre", 32'(host_data_in), 32'h3C);
    rst = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_hcmd", 32'(host_cmd), 32'h0);
    chk("ar_hdata", 32'(host_data_in), 32'hFF);
    chk("ar_m1busy", 32'(m1_busy), 32'h0);
    chk("ar_tmo", 32'(timeout_err), 32'h0);

    // last_owner returns to 1 after reset: m0 wins the tie again
    host_busy = 1'b0; m0_cmd = 6'b000010; m1_cmd = 6'b000010;
    step();
    rst = 1'b1;
    step();
    chk("ar_tie_grant", 32'(grant), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
